exc_seq: RTL and testbench

Exception sequencer for the multicycle MIPS core. On a one-cycle exception request from the control unit (invalid opcode, ALU overflow, divide by zero), it takes over the PC/EPC/memory-address path for a fixed number of cycles and then releases it. During that window it saves the faulting address to EPC, fetches the handler vector byte from memory, and loads PC. It also sequences return-from-exception (PC ← EPC). The control unit stalls while `Busy` is high.

---
 rtl/exc_pkg.sv | 27 ++
 rtl/exc_seq.sv | 164 ++++++++++++++++
 tb/tb_exc_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer.
//   exc_state_t : sequencer FSM states
//   exc_cause_t : encoding of the Cause output (0 none, 1 opcode, 2 overflow, 3 div)
//   VEC_*_DFLT  : default handler vector byte addresses
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SAVE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_LOAD  = 3'd4,
    ST_RET   = 3'd5
  } exc_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_OPC  = 2'd1,
    CAUSE_OVF  = 2'd2,
    CAUSE_DIV  = 2'd3
  } exc_cause_t;

  localparam logic [7:0] VEC_OPC_DFLT = 8'd253;
  localparam logic [7:0] VEC_OVF_DFLT = 8'd254;
  localparam logic [7:0] VEC_DIV_DFLT = 8'd255;

endpackage

// File: rtl/exc_seq.sv
// Exception sequencer for the multicycle MIPS core.
// On a one-cycle exception request it owns the PC/EPC/address path:
// SAVE (EPC <= PC-4), FETCH + WAIT (vector address on the memory bus),
// LOAD (PC <= vector byte). Eret runs a single RET cycle (PC <= EPC).
// Ports:
//   Clk, Reset (async, active low)
//   ReqOpc/ReqOvf/ReqDiv/Eret : one-cycle request pulses
//   ClrLost                   : clears the sticky ExcLost flag
//   PC, EPC, VecByte          : datapath inputs
//   Busy, Done                : ownership / final-cycle pulse
//   EPCWrite/EpcData, PCWrite/PcData, AddrOvr/VecAddr : path overrides
//   Cause, ExcLost            : status
//   DbgState                  : current FSM state for observation
// Handshake: requests are only accepted while Busy is low; any request seen
// while Busy is high is dropped and recorded in ExcLost.
module exc_seq
  import exc_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1,
  parameter logic [7:0]  VEC_OPC  = VEC_OPC_DFLT,
  parameter logic [7:0]  VEC_OVF  = VEC_OVF_DFLT,
  parameter logic [7:0]  VEC_DIV  = VEC_DIV_DFLT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqOpc,
  input  logic        ReqOvf,
  input  logic        ReqDiv,
  input  logic        Eret,
  input  logic        ClrLost,
  input  logic [31:0] PC,
  input  logic [31:0] EPC,
  input  logic [7:0]  VecByte,
  output logic        Busy,
  output logic        Done,
  output logic        EPCWrite,
  output logic [31:0] EpcData,
  output logic        PCWrite,
  output logic [31:0] PcData,
  output logic        AddrOvr,
  output logic [31:0] VecAddr,
  output logic [1:0]  Cause,
  output logic        ExcLost,
  output exc_state_t  DbgState
);

  // Counter holds at most MEM_WAIT-1.
  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_WAIT - 1);

  exc_state_t    state_q, state_d;
  exc_cause_t    cause_q, cause_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lost_q, lost_d;
  logic          any_req;
  logic [7:0]    vec_byte_addr;

  assign any_req = ReqOpc | ReqOvf | ReqDiv;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
    end
  end

  // Next state, counter and cause.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          // Exceptions beat a simultaneous Eret; opcode > overflow > div.
          state_d = ST_SAVE;
          if (ReqOpc)      cause_d = CAUSE_OPC;
          else if (ReqOvf) cause_d = CAUSE_OVF;
          else             cause_d = CAUSE_DIV;
        end else if (Eret) begin
          state_d = ST_RET;
        end
      end
      ST_SAVE:  state_d = ST_FETCH;
      ST_FETCH: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_LOAD;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_LOAD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_LOAD:  state_d = ST_IDLE;
      ST_RET:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sticky lost flag: a new drop in the same cycle as a clear keeps it set.
  always_comb begin
    lost_d = lost_q & ~ClrLost;
    if ((state_q != ST_IDLE) && (any_req || Eret)) lost_d = 1'b1;
  end

  always_comb begin
    case (cause_q)
      CAUSE_OPC: vec_byte_addr = VEC_OPC;
      CAUSE_OVF: vec_byte_addr = VEC_OVF;
      CAUSE_DIV: vec_byte_addr = VEC_DIV;
      default:   vec_byte_addr = 8'd0;
    endcase
  end

  // Moore outputs; PcData in LOAD passes VecByte straight through.
  always_comb begin
    Busy     = 1'b0;
    Done     = 1'b0;
    EPCWrite = 1'b0;
    EpcData  = 32'd0;
    PCWrite  = 1'b0;
    PcData   = 32'd0;
    AddrOvr  = 1'b0;
    VecAddr  = 32'd0;
    case (state_q)
      ST_SAVE: begin
        Busy     = 1'b1;
        EPCWrite = 1'b1;
        EpcData  = PC - 32'd4;  // wraps: PC=0 gives 0xFFFFFFFC
      end
      ST_FETCH, ST_WAIT: begin
        Busy    = 1'b1;
        AddrOvr = 1'b1;
        VecAddr = {24'd0, vec_byte_addr};
      end
      ST_LOAD: begin
        Busy    = 1'b1;
        AddrOvr = 1'b1;
        VecAddr = {24'd0, vec_byte_addr};
        PCWrite = 1'b1;
        PcData  = {24'd0, VecByte};
        Done    = 1'b1;
      end
      ST_RET: begin
        Busy    = 1'b1;
        PCWrite = 1'b1;
        PcData  = EPC;
        Done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign Cause    = cause_q;
  assign ExcLost  = lost_q;
  assign DbgState = state_q;

endmodule

// File: tb/tb_exc_seq.sv
// Directed bench for exc_seq. Two instances share all inputs: u1 with
// MEM_WAIT=1 (main checks) and u3 with MEM_WAIT=3 (long-wait sequence).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_exc_seq;
  import exc_pkg::*;

  logic        Clk, Reset;
  logic        ReqOpc, ReqOvf, ReqDiv, Eret, ClrLost;
  logic [31:0] PC, EPC;
  logic [7:0]  VecByte;

  logic        Busy, Done, EPCWrite, PCWrite, AddrOvr, ExcLost;
  logic [31:0] EpcData, PcData, VecAddr;
  logic [1:0]  Cause;
  exc_state_t  DbgState;

  logic        m3_Busy, m3_Done, m3_EPCWrite, m3_PCWrite, m3_AddrOvr, m3_ExcLost;
  logic [31:0] m3_EpcData, m3_PcData, m3_VecAddr;
  logic [1:0]  m3_Cause;
  exc_state_t  m3_DbgState;

  int checks;
  int failures;

  exc_seq #(.MEM_WAIT(1)) u1 (
    .Clk(Clk), .Reset(Reset), .ReqOpc(ReqOpc), .ReqOvf(ReqOvf), .ReqDiv(ReqDiv),
    .Eret(Eret), .ClrLost(ClrLost), .PC(PC), .EPC(EPC), .VecByte(VecByte),
    .Busy(Busy), .Done(Done), .EPCWrite(EPCWrite), .EpcData(EpcData),
    .PCWrite(PCWrite), .PcData(PcData), .AddrOvr(AddrOvr), .VecAddr(VecAddr),
    .Cause(Cause), .ExcLost(ExcLost), .DbgState(DbgState)
  );

  exc_seq #(.MEM_WAIT(3)) u3 (
    .Clk(Clk), .Reset(Reset), .ReqOpc(ReqOpc), .ReqOvf(ReqOvf), .ReqDiv(ReqDiv),
    .Eret(Eret), .ClrLost(ClrLost), .PC(PC), .EPC(EPC), .VecByte(VecByte),
    .Busy(m3_Busy), .Done(m3_Done), .EPCWrite(m3_EPCWrite), .EpcData(m3_EpcData),
    .PCWrite(m3_PCWrite), .PcData(m3_PcData), .AddrOvr(m3_AddrOvr), .VecAddr(m3_VecAddr),
    .Cause(m3_Cause), .ExcLost(m3_ExcLost), .DbgState(m3_DbgState)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},    32'(Busy),     32'd0);
    chk({tag, "_done"},    32'(Done),     32'd0);
    chk({tag, "_epcwr"},   32'(EPCWrite), 32'd0);
    chk({tag, "_epcdata"}, EpcData,       32'd0);
    chk({tag, "_pcwr"},    32'(PCWrite),  32'd0);
    chk({tag, "_pcdata"},  PcData,        32'd0);
    chk({tag, "_addrovr"}, 32'(AddrOvr),  32'd0);
    chk({tag, "_vecaddr"}, VecAddr,       32'd0);
  endtask

  int busy1, busy3, done3, pcwr_seen;

  initial begin
    checks = 0; failures = 0;
    Reset = 1'b0;
    ReqOpc = 0; ReqOvf = 0; ReqDiv = 0; Eret = 0; ClrLost = 0;
    PC = 32'd0; EPC = 32'd0; VecByte = 8'd0;

    // Reset state
    cyc(); cyc();
    chk_idle_outputs("rst");
    chk("rst_cause", 32'(Cause),    32'd0);
    chk("rst_lost",  32'(ExcLost),  32'd0);
    chk("rst_state", 32'(DbgState), 32'(ST_IDLE));
    Reset = 1'b1;
    cyc();

    // Overflow exception, MEM_WAIT=1
    PC = 32'h0000_0010; VecByte = 8'h40; ReqOvf = 1;
    cyc(); ReqOvf = 0;                                     // cycle 1: SAVE
    chk("ovf_c1_busy",    32'(Busy),     32'd1);
    chk("ovf_c1_epcwr",   32'(EPCWrite), 32'd1);
    chk("ovf_c1_epcdata", EpcData,       32'h0000_000C);
    chk("ovf_c1_cause",   32'(Cause),    32'd2);
    chk("ovf_c1_addrovr", 32'(AddrOvr),  32'd0);
    cyc();                                                 // cycle 2: FETCH
    chk("ovf_c2_addrovr", 32'(AddrOvr),  32'd1);
    chk("ovf_c2_vecaddr", VecAddr,       32'd254);
    chk("ovf_c2_epcwr",   32'(EPCWrite), 32'd0);
    chk("ovf_c2_epcdata", EpcData,       32'd0);
    cyc();                                                 // cycle 3: WAIT
    chk("ovf_c3_vecaddr", VecAddr,       32'd254);
    chk("ovf_c3_pcwr",    32'(PCWrite),  32'd0);
    chk("ovf_c3_busy",    32'(Busy),     32'd1);
    cyc();                                                 // cycle 4: LOAD
    chk("ovf_c4_pcwr",    32'(PCWrite),  32'd1);
    chk("ovf_c4_done",    32'(Done),     32'd1);
    chk("ovf_c4_pcdata",  PcData,        32'h0000_0040);
    chk("ovf_c4_vecaddr", VecAddr,       32'd254);
    VecByte = 8'h9A;                                       // combinational pass-through
    #1 chk("ovf_c4_pcdata_pass", PcData, 32'h0000_009A);
    cyc();
    chk_idle_outputs("ovf_c5");
    chk("ovf_c5_cause", 32'(Cause), 32'd2);

    // Opcode + div together: opcode wins
    ReqOpc = 1; ReqDiv = 1;
    cyc(); ReqOpc = 0; ReqDiv = 0;
    chk("pri_cause", 32'(Cause), 32'd1);
    cyc();
    chk("pri_vecaddr", VecAddr, 32'd253);
    cyc(); cyc();                                          // WAIT, LOAD
    chk("pri_done", 32'(Done), 32'd1);
    cyc();
    chk("pri_lost", 32'(ExcLost), 32'd0);

    // Eret: single RET cycle, Cause untouched
    EPC = 32'h0000_0108; Eret = 1;
    cyc(); Eret = 0;
    chk("ret_pcwr",   32'(PCWrite), 32'd1);
    chk("ret_pcdata", PcData,       32'h0000_0108);
    chk("ret_busy",   32'(Busy),    32'd1);
    chk("ret_done",   32'(Done),    32'd1);
    chk("ret_cause",  32'(Cause),   32'd1);
    chk("ret_addrovr",32'(AddrOvr), 32'd0);
    cyc();
    chk("ret_after_busy", 32'(Busy), 32'd0);

    // Request dropped during WAIT sets ExcLost
    ReqOvf = 1;
    cyc(); ReqOvf = 0;                                     // SAVE
    cyc();                                                 // FETCH
    cyc();                                                 // WAIT
    ReqDiv = 1;
    cyc(); ReqDiv = 0;                                     // LOAD
    chk("lost_set",      32'(ExcLost), 32'd1);
    chk("lost_cause",    32'(Cause),   32'd2);
    chk("lost_vecaddr",  VecAddr,      32'd254);
    cyc();
    chk("lost_hold1", 32'(ExcLost), 32'd1);
    chk("lost_idle",  32'(DbgState), 32'(ST_IDLE));
    cyc();
    chk("lost_hold2", 32'(ExcLost), 32'd1);
    ClrLost = 1;
    cyc(); ClrLost = 0;
    chk("lost_clr", 32'(ExcLost), 32'd0);
    // Set and clear in the same cycle: set wins
    Eret = 1;
    cyc(); Eret = 0;                                       // RET
    ReqOpc = 1; ClrLost = 1;
    cyc(); ReqOpc = 0; ClrLost = 0;
    chk("lost_setwins", 32'(ExcLost), 32'd1);
    chk("lost_ignored_state", 32'(DbgState), 32'(ST_IDLE));
    ClrLost = 1;
    cyc(); ClrLost = 0;
    chk("lost_clr2", 32'(ExcLost), 32'd0);

    // Reset asserted in FETCH
    ReqOpc = 1;
    cyc(); ReqOpc = 0;                                     // SAVE
    cyc();                                                 // FETCH
    chk("rstf_addrovr_pre", 32'(AddrOvr), 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk_idle_outputs("rstf");
    chk("rstf_cause", 32'(Cause),    32'd0);
    chk("rstf_state", 32'(DbgState), 32'(ST_IDLE));
    cyc();
    Reset = 1'b1;
    pcwr_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (PCWrite || m3_PCWrite) pcwr_seen++;
    end
    chk("rstf_no_pcwrite", 32'(pcwr_seen), 32'd0);

    // MEM_WAIT=3 on u3 (u1 runs alongside), PC=0 wraps
    PC = 32'd0; VecByte = 8'h77; ReqDiv = 1;
    cyc(); ReqDiv = 0;
    chk("mw3_epcwr",   32'(m3_EPCWrite), 32'd1);
    chk("mw3_epcdata", m3_EpcData,       32'hFFFF_FFFC);
    chk("mw1_epcdata", EpcData,          32'hFFFF_FFFC);
    cyc();
    chk("mw3_vecaddr", m3_VecAddr, 32'd255);
    busy1 = 2; busy3 = 2; done3 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (Busy)    busy1++;
      if (m3_Busy) busy3++;
      if (m3_Done) begin
        done3++;
        chk("mw3_pcdata", m3_PcData, 32'h0000_0077);
      end
    end
    chk("mw3_busy_cycles", 32'(busy3), 32'd6);
    chk("mw1_busy_cycles", 32'(busy1), 32'd4);
    chk("mw3_done_count",  32'(done3), 32'd1);
    chk("mw3_cause",       32'(m3_Cause), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
